fp_alu_pipe: RTL and testbench
==============================

// Module: fp_alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle floating-point ALU.
//  Performs IEEE-754-style add, sub and mul, plus bitwise AND/OR/NOT, on a configurable float format.
//  Operands enter through a valid/ready handshake and pass through a fixed 3-stage pipeline: unpack/special-case, compute, normalise/pack.
//  Results leave with status flags and a pass-through tag, so upstream logic can issue back-to-back operations under backpressure.
// PARAMETERS
//  EXP_W  8   exponent width; W = 1+EXP_W+MAN_W is the operand/result width
//  MAN_W  23  stored mantissa width; the hidden bit is implicit
//  TAG_W  4   width of the user tag carried alongside each operation
// PORTS
//  clk        in   1      clock; all flops on rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  in_valid   in   1      operation offered
//  in_ready   out  1      operation accepted when in_valid & in_ready
//  in_op      in   3      000 ADD, 001 SUB, 010 reserved, 011 MUL, 100 AND, 101 OR, 110 NOT(A), 111 reserved
//  in_a       in   W      operand A
//  in_b       in   W      operand B; ignored for NOT
//  in_tag     in   TAG_W  user tag, returned unchanged with the result
//  out_valid  out  1      result present
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_data   out  W      result
//  out_tag    out  TAG_W  tag of this result
//  out_nv     out  1      invalid-operation flag
//  out_of     out  1      overflow flag
//  out_uf     out  1      underflow flag
// BEHAVIOUR
//  Reset:
//  - While rst_n=0, all stage-valid bits, out_valid, out_data, out_tag and all flags are 0.
//  - in_ready is 0 during reset; after reset it equals advance, so it is 1 with the pipeline empty.
//  - Reset asserted mid-operation discards every in-flight operation; none is reported after release.
//  Pipeline and handshake:
//  - advance = !out_valid | out_ready; in_ready = advance.
//  - All stages shift together on advance and hold otherwise; bubbles are not collapsed.
//  - Latency: a result accepted at edge N shows out_valid=1 after edge N+3, provided advance holds.
//  - Throughput: one operation per cycle. Order is strictly preserved.
//  - out_* stay stable while out_valid=1 and out_ready=0.
//  Format:
//  - An exponent field of all ones with mantissa=0 is inf; with mantissa!=0 it is NaN.
//  - Denormal inputs are flushed to signed zero; no denormal outputs are produced.
//  - Rounding is truncation (round toward zero).
//  - Canonical qNaN = {0, all-ones exponent, 1, zeros}.
//  ADD/SUB:
//  - SUB is ADD with the sign of B inverted.
//  - Either operand NaN -> qNaN, nv=1.
//  - inf + (-inf) -> qNaN, nv=1.
//  - inf + finite -> the inf.
//  - x + 0 -> x.
//  - (-0) + (-0) -> -0; exact cancellation -> +0.
//  - Alignment uses the larger exponent; shifts >= MAN_W+3 leave the smaller operand as sticky-only.
//  - Normalise with a leading-zero count.
//  MUL:
//  - Sign = sA^sB. Any NaN -> qNaN, nv=1; 0*inf -> qNaN, nv=1; inf*finite-nonzero -> signed inf.
//  - Zero operand -> signed zero.
//  - Full (MAN_W+1)x(MAN_W+1) product, exponent = eA+eB-bias, normalised by at most 1 bit.
//  Range (arithmetic results):
//  - Biased exponent >= all-ones -> signed inf, of=1.
//  - Biased exponent < 1 -> signed zero, uf=1.
//  Bitwise ops:
//  - AND/OR/NOT operate on raw W-bit vectors; flags are 0.
//  - NOT returns ~A.
//  Reserved opcodes (010, 111):
//  - out_data = qNaN, nv=1; still occupy one pipeline slot and complete in order.
// TESTING (default params)
//  1. ADD 0x3F800000 + 0x40000000, tag 5 -> 3 cycles later out_data=0x40400000, out_tag=5, flags 0.
//  2. MUL 0x3FC00000 * 0xC0000000 -> 0xC0400000.
//     MUL 0x7F000000 * 0x7F000000 -> 0x7F800000, of=1.
//  3. SUB 0x7F800000 - 0x7F800000 -> 0x7FC00000, nv=1.
//     SUB 0x40400000 - 0x40400000 -> 0x00000000.
//  4. AND 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0.
//     NOT 0x00000000 -> 0xFFFFFFFF.
//     op 010 -> 0x7FC00000, nv=1.
//  5. Issue 6 back-to-back ops, tags 0..5, with out_ready=0 for 6 cycles:
//     - in_ready drops once the three stages and the output register are full.
//     - After out_ready=1, tags 0..5 emerge in order with no loss or duplication.
//  6. Drop rst_n with 3 ops in flight -> out_valid=0 immediately.
//     After release, no stale result appears and a fresh ADD completes in 3 cycles.

Source files
------------

// File: rtl/fp_alu_pipe.sv
// Pipelined floating-point ALU: add/sub/mul on a configurable float format plus raw bitwise ops.
// Four register slices (unpack, compute, normalise, output) advance together under valid/ready flow control.
module fp_alu_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_nv,
    output logic                   out_of,
    output logic                   out_uf
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int F    = MAN_W + 1;
    localparam int R    = 2 * F;
    localparam int EW   = EXP_W + $clog2(R) + 2;
    localparam int LZW  = $clog2(R + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b011,
                           OP_AND = 3'b100, OP_OR  = 3'b101, OP_NOT = 3'b110;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE = EW'(1);

    function automatic logic [LZW-1:0] lzc(input logic [R-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(R);
        for (int i = 0; i < R; i++)
            if (v[i]) n = LZW'(R - 1 - i);
        return n;
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = rst_n && advance;

    // unpack and special-case classification
    logic             sa, sb_eff, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, mul_sign;
    logic [EXP_W-1:0] ea, eb;
    logic             sp;
    logic [W-1:0]     sp_data;
    logic             sp_nv;

    assign sa       = in_a[W-1];
    assign ea       = in_a[W-2:MAN_W];
    assign eb       = in_b[W-2:MAN_W];
    assign sb_eff   = in_b[W-1] ^ (in_op == OP_SUB);
    assign mul_sign = sa ^ in_b[W-1];
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (&ea) && (in_a[MAN_W-1:0] == '0);
    assign b_inf    = (&eb) && (in_b[MAN_W-1:0] == '0);
    assign a_nan    = (&ea) && (in_a[MAN_W-1:0] != '0);
    assign b_nan    = (&eb) && (in_b[MAN_W-1:0] != '0);

    always_comb begin
        sp      = 1'b1;
        sp_data = QNAN;
        sp_nv   = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB: begin
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb_eff))) sp_nv = 1'b1;
                else if (a_inf)             sp_data = in_a;
                else if (b_inf)             sp_data = {sb_eff, in_b[W-2:0]};
                else if (a_zero && b_zero)  sp_data = {sa & sb_eff, {(W-1){1'b0}}};
                else if (b_zero)            sp_data = in_a;
                else if (a_zero)            sp_data = {sb_eff, in_b[W-2:0]};
                else                        sp      = 1'b0;
            end
            OP_MUL: begin
                if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) sp_nv = 1'b1;
                else if (a_inf || b_inf)    sp_data = {mul_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (a_zero || b_zero)  sp_data = {mul_sign, {(W-1){1'b0}}};
                else                        sp      = 1'b0;
            end
            OP_AND:  sp_data = in_a & in_b;
            OP_OR:   sp_data = in_a | in_b;
            OP_NOT:  sp_data = ~in_a;
            default: sp_nv   = 1'b1;
        endcase
    end

    logic             s1_valid, s1_mul, s1_sp, s1_nv, s1_sa, s1_sb;
    logic [TAG_W-1:0] s1_tag;
    logic [W-1:0]     s1_spd;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [F-1:0]     s1_ma, s1_mb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0; s1_mul <= 1'b0; s1_sp <= 1'b0; s1_nv <= 1'b0;
            s1_sa <= 1'b0; s1_sb <= 1'b0; s1_tag <= '0; s1_spd <= '0;
            s1_ea <= '0; s1_eb <= '0; s1_ma <= '0; s1_mb <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_mul   <= (in_op == OP_MUL);
            s1_sp    <= sp;
            s1_nv    <= sp_nv;
            s1_spd   <= sp_data;
            s1_tag   <= in_tag;
            s1_sa    <= sa;
            s1_sb    <= sb_eff;
            s1_ea    <= ea;
            s1_eb    <= eb;
            s1_ma    <= {1'b1, in_a[MAN_W-1:0]};
            s1_mb    <= {1'b1, in_b[MAN_W-1:0]};
        end
    end

    // compute: aligned add/sub with 3 guard bits, or full product
    logic             a_big, s_big, s_small;
    logic [EXP_W-1:0] e_big, e_small, d;
    logic [F-1:0]     m_big, m_small;
    logic [F+2:0]     sx, s_al, mask;
    logic [F+3:0]     sum;
    logic [R-1:0]     prod;
    logic signed [EW-1:0] e_mul;

    always_comb begin
        a_big   = {s1_ea, s1_ma} >= {s1_eb, s1_mb};
        e_big   = a_big ? s1_ea : s1_eb;
        e_small = a_big ? s1_eb : s1_ea;
        m_big   = a_big ? s1_ma : s1_mb;
        m_small = a_big ? s1_mb : s1_ma;
        s_big   = a_big ? s1_sa : s1_sb;
        s_small = a_big ? s1_sb : s1_sa;
        d       = e_big - e_small;
        sx      = {m_small, 3'b000};
        mask    = ~({(F+3){1'b1}} << d);
        if (32'(d) >= MAN_W + 3) s_al = {{(F+2){1'b0}}, 1'b1};
        else                     s_al = (sx >> d) | {{(F+2){1'b0}}, |(sx & mask)};
        if (s_big == s_small) sum = {1'b0, m_big, 3'b000} + {1'b0, s_al};
        else                  sum = {1'b0, m_big, 3'b000} - {1'b0, s_al};
        prod  = R'(s1_ma) * R'(s1_mb);
        e_mul = EW'(s1_ea) + EW'(s1_eb) - EW'(BIAS);
    end

    logic             s2_valid, s2_sp, s2_nv, s2_sign;
    logic [TAG_W-1:0] s2_tag;
    logic [W-1:0]     s2_spd;
    logic signed [EW-1:0] s2_exp;
    logic [R-1:0]     s2_man;

    // both paths leave the hidden bit at R-2 for exponent s2_exp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0; s2_sp <= 1'b0; s2_nv <= 1'b0; s2_sign <= 1'b0;
            s2_tag <= '0; s2_spd <= '0; s2_exp <= '0; s2_man <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sp    <= s1_sp;
            s2_nv    <= s1_nv;
            s2_spd   <= s1_spd;
            s2_tag   <= s1_tag;
            s2_sign  <= s1_mul ? (s1_sa ^ s1_sb) : s_big;
            s2_exp   <= s1_mul ? e_mul : EW'(e_big);
            s2_man   <= s1_mul ? prod : {sum, {(R-F-4){1'b0}}};
        end
    end

    logic [LZW-1:0]       lz;
    logic [MAN_W-1:0]     man_n;
    logic signed [EW-1:0] exp_n;

    assign lz    = lzc(s2_man);
    assign man_n = MAN_W'((s2_man << lz) >> (R - 1 - MAN_W));
    assign exp_n = s2_exp + EW'(1) - EW'(lz);

    logic             s3_valid, s3_sp, s3_nv, s3_sign, s3_zero;
    logic [TAG_W-1:0] s3_tag;
    logic [W-1:0]     s3_spd;
    logic signed [EW-1:0] s3_exp;
    logic [MAN_W-1:0] s3_man;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0; s3_sp <= 1'b0; s3_nv <= 1'b0; s3_sign <= 1'b0; s3_zero <= 1'b0;
            s3_tag <= '0; s3_spd <= '0; s3_exp <= '0; s3_man <= '0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_sp    <= s2_sp;
            s3_nv    <= s2_nv;
            s3_spd   <= s2_spd;
            s3_tag   <= s2_tag;
            s3_sign  <= s2_sign;
            s3_zero  <= (s2_man == '0);
            s3_exp   <= exp_n;
            s3_man   <= man_n;
        end
    end

    logic [W-1:0] pk_data;
    logic         pk_nv, pk_of, pk_uf;

    always_comb begin
        pk_data = {s3_sign, s3_exp[EXP_W-1:0], s3_man};
        pk_nv   = 1'b0;
        pk_of   = 1'b0;
        pk_uf   = 1'b0;
        if (s3_sp) begin
            pk_data = s3_spd;
            pk_nv   = s3_nv;
        end else if (s3_zero) begin
            pk_data = '0;
        end else if (s3_exp >= E_MAX) begin
            pk_data = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pk_of   = 1'b1;
        end else if (s3_exp < E_ONE) begin
            pk_data = {s3_sign, {(W-1){1'b0}}};
            pk_uf   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0; out_data <= '0; out_tag <= '0;
            out_nv <= 1'b0; out_of <= 1'b0; out_uf <= 1'b0;
        end else if (advance) begin
            out_valid <= s3_valid;
            out_data  <= pk_data;
            out_tag   <= s3_tag;
            out_nv    <= pk_nv;
            out_of    <= pk_of;
            out_uf    <= pk_uf;
        end
    end
endmodule

// File: tb/tb_fp_alu_pipe.sv
// Scoreboard bench for fp_alu_pipe at the default single-precision format.
module tb_fp_alu_pipe;
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_R2 = 3'b010, OP_MUL = 3'b011,
                           OP_AND = 3'b100, OP_OR  = 3'b101, OP_NOT = 3'b110, OP_R7 = 3'b111;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_data;
    logic [3:0]  in_tag, out_tag;
    logic        out_nv, out_of, out_uf;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic [2:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0, n_fail = 0, n_pushed = 0, n_popped = 0, tag_ctr = 0;

    always #5 clk = ~clk;

    fp_alu_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_nv(out_nv), .out_of(out_of), .out_uf(out_uf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] res, input logic [2:0] flags);
        int   waited = 0;
        exp_t e;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("issue_accept", 32'(in_ready), 1);
        if (in_ready) begin
            e.data = res; e.tag = tag; e.flags = flags;
            sb_q.push_back(e);
            n_pushed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [2:0] flags);
        issue(op, a, b, 4'(tag_ctr), res, flags);
        tag_ctr++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 0);
        @(posedge clk); #1;
    endtask

    // pipeline must be empty on entry; checks the 3-edge latency
    task automatic lat_add(input logic [3:0] tag);
        issue(OP_ADD, 32'h3F800000, 32'h40000000, tag, 32'h40400000, 3'b000);
        check("lat_e0", 32'(out_valid), 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("lat_mid", 32'(out_valid), 0);
        end
        @(posedge clk); #1;
        check("lat_e3", 32'(out_valid), 1);
        check("lat_data", out_data, 32'h40400000);
        check("lat_tag", 32'(out_tag), 32'(tag));
    endtask

    initial begin : monitor
        exp_t        e;
        bit          held = 1'b0;
        logic [31:0] held_data;
        logic [3:0]  held_tag;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (out_valid && held) begin
                    check("stable_data", out_data, held_data);
                    check("stable_tag", 32'(out_tag), 32'(held_tag));
                end
                held      = out_valid && !out_ready;
                held_data = out_data;
                held_tag  = out_tag;
                if (out_valid && out_ready) begin
                    check("sb_nonempty", 32'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        n_popped++;
                        check($sformatf("data t%0d", e.tag), out_data, e.data);
                        check($sformatf("tag t%0d", e.tag), 32'(out_tag), 32'(e.tag));
                        check($sformatf("flags t%0d", e.tag), 32'({out_nv, out_of, out_uf}), 32'(e.flags));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] ra, rb;
        int          discarded;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_flags", 32'({out_nv, out_of, out_uf}), 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(in_ready), 1);
        @(posedge clk); #1;

        lat_add(4'd5);
        drain();

        // flags are {nv, of, uf}
        vec(OP_MUL, 32'h3FC00000, 32'hC0000000, 32'hC0400000, 3'b000);
        vec(OP_MUL, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
        vec(OP_SUB, 32'h7F800000, 32'h7F800000, QNAN,         3'b100);
        vec(OP_SUB, 32'h40400000, 32'h40400000, 32'h00000000, 3'b000);
        vec(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 3'b000);
        vec(OP_NOT, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 3'b000);
        vec(OP_R2,  32'h3F800000, 32'h3F800000, QNAN,         3'b100);
        vec(OP_R7,  32'h00000000, 32'h00000000, QNAN,         3'b100);
        vec(OP_ADD, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
        vec(OP_ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000);
        vec(OP_ADD, 32'h7F800000, 32'hFF800000, QNAN,         3'b100);
        vec(OP_MUL, 32'h00000000, 32'h7F800000, QNAN,         3'b100);
        vec(OP_MUL, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
        vec(OP_MUL, 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
        vec(OP_ADD, 32'h7F800001, 32'h3F800000, QNAN,         3'b100);
        vec(OP_ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000);
        vec(OP_ADD, 32'h3F800000, 32'h30800000, 32'h3F800000, 3'b000);
        vec(OP_SUB, 32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 3'b000);
        vec(OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010);
        vec(OP_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 3'b000);
        vec(OP_ADD, 32'h3FC00000, 32'hBF000000, 32'h3F800000, 3'b000);
        vec(OP_MUL, 32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000);
        vec(OP_MUL, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
        vec(OP_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
        vec(OP_SUB, 32'h3F800000, 32'h3FC00000, 32'hBF000000, 3'b000);

        for (int i = 0; i < 9; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 3)
                0:       vec(OP_AND, ra, rb, ra & rb, 3'b000);
                1:       vec(OP_OR,  ra, rb, ra | rb, 3'b000);
                default: vec(OP_NOT, ra, rb, ~ra,     3'b000);
            endcase
        end
        drain();

        // backpressure: four ops fill the slices, the rest wait on in_ready
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ra = $urandom;
                    issue(OP_NOT, ra, 32'h0, 4'(i), ~ra, 3'b000);
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_in_ready", 32'(in_ready), 0);
                check("bp_out_valid", 32'(out_valid), 1);
                check("bp_inflight", 32'(sb_q.size()), 4);
                check("bp_head_tag", 32'(out_tag), 0);
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) vec(OP_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
        @(posedge clk); #1;
        check("rst_pre_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        discarded = sb_q.size();
        n_pushed  = n_pushed - discarded;
        sb_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_flags", 32'({out_nv, out_of, out_uf}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale", 32'(out_valid), 0);
        end
        lat_add(4'd9);
        drain();

        check("count", 32'(n_popped), 32'(n_pushed));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
